// File: rtl/trace_buffer_if.sv
// Capture and read-out channels of the trace buffer.
// The master side drives captures and accepts entries; the slave side is the buffer.
interface trace_buffer_if #(
  parameter int unsigned XLEN = 32
);
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [XLEN-1:0] cap_inst;
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_inst;

  modport master (
    output cap_valid, cap_pc, cap_inst, rd_ready,
    input  rd_valid, rd_pc, rd_inst
  );

  modport slave (
    input  cap_valid, cap_pc, cap_inst, rd_ready,
    output rd_valid, rd_pc, rd_inst
  );
endinterface

// File: rtl/trace_buffer.sv
// Post-trigger trace capture FIFO: records PC/instruction pairs, freezes a
// programmable number of captures after a trigger, and drains in FIFO order.
module trace_buffer #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    clear,
  input  logic                    trig,
  trace_buffer_if.slave           bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             drops,
  output logic                    frozen
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    POST   = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] post_cnt;

  logic [XLEN-1:0]  mem_pc   [DEPTH];
  logic [XLEN-1:0]  mem_inst [DEPTH];

  logic push;
  logic pop;
  logic full;
  logic wr_en;
  logic overwrite;
  logic drop_evt;

  assign full      = (count == CNT_W'(DEPTH));
  assign push      = en && bus.cap_valid && (state != FROZEN);
  assign pop       = bus.rd_valid && bus.rd_ready;
  // When full, a concurrent pop frees the slot the push lands in.
  assign wr_en     = push && (pop || !full || mode);
  assign overwrite = push && full && !pop && mode;
  assign drop_evt  = push && full && !pop;

  assign bus.rd_valid = (count != '0);
  assign bus.rd_pc    = mem_pc[rptr];
  assign bus.rd_inst  = mem_inst[rptr];

  // Trigger sequencing: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARMED;
    end else begin
      state <= state_d;
    end
  end

  // Trigger sequencing: next state.
  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = ARMED;
    end else begin
      case (state)
        ARMED: begin
          if (trig) begin
            state_d = (POST_TRIG == 0) ? FROZEN : POST;
          end
        end
        POST: begin
          if (push && (post_cnt == CNT_W'(1))) begin
            state_d = FROZEN;
          end
        end
        FROZEN:  state_d = FROZEN;
        default: state_d = ARMED;
      endcase
    end
  end

  // Trigger sequencing: outputs.
  always_comb begin
    frozen = 1'b0;
    if (state == FROZEN) begin
      frozen = 1'b1;
    end
  end

  // Captures remaining after the trigger; the trigger-cycle push is not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      post_cnt <= '0;
    end else if (clear) begin
      post_cnt <= '0;
    end else if ((state == ARMED) && trig) begin
      post_cnt <= CNT_W'(POST_TRIG);
    end else if ((state == POST) && push) begin
      post_cnt <= post_cnt - CNT_W'(1);
    end
  end

  // Pointers, occupancy and the saturating lost-entry counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      drops <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      drops <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop || overwrite) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (push && !pop && !full) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
      if (drop_evt && (drops != 16'hFFFF)) begin
        drops <= drops + 16'd1;
      end
    end
  end

  // Entry storage carries no reset; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem_pc[wptr]   <= bus.cap_pc;
      mem_inst[wptr] <= bus.cap_inst;
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer at DEPTH=4, POST_TRIG=2: expected entries are
// queued as captures are driven and compared as the buffer is drained.
module tb_trace_buffer;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned POST_TRIG = 2;
  localparam int unsigned CW        = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          en;
  logic          mode;
  logic          clear;
  logic          trig;
  logic [CW-1:0] count;
  logic [15:0]   drops;
  logic          frozen;

  trace_buffer_if #(.XLEN(XLEN)) bus ();

  trace_buffer #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .POST_TRIG (POST_TRIG)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .clear  (clear),
    .trig   (trig),
    .bus    (bus),
    .count  (count),
    .drops  (drops),
    .frozen (frozen)
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [XLEN-1:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required test end");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock and settle just past the active edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [XLEN-1:0] pc);
    bus.cap_valid = 1'b1;
    bus.cap_pc    = pc;
    bus.cap_inst  = ~pc;
    cycle();
    bus.cap_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic pop_one(output logic got, output logic [XLEN-1:0] pc, output logic [XLEN-1:0] inst);
    got  = bus.rd_valid;
    pc   = bus.rd_pc;
    inst = bus.rd_inst;
    bus.rd_ready = got;
    cycle();
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (bus.rd_valid !== 1'b0 || count !== '0 || drops !== 16'd0 || frozen !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: rd_valid=%b count=%0d drops=%0d frozen=%b, required 0/0/0/0",
               bus.rd_valid, count, drops, frozen);
    end
    cycle();
    reset = 1'b1;
    cycle();
    n_checks++;
    if (count !== '0 || frozen !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_release: count=%0d frozen=%b, required 0/0", count, frozen);
    end
  endtask

  task automatic test_stop_when_full();
    logic got;
    logic [XLEN-1:0] pc, inst, e;
    do_clear();
    mode = 1'b0;
    en   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cap(XLEN'(32'h10 + 4 * i));
      if (i < 4) exp_q.push_back(XLEN'(32'h10 + 4 * i));
    end
    n_checks++;
    if (count !== CW'(4) || drops !== 16'd1) begin
      n_fails++;
      $display("FAIL stop_full_occupancy: count=%0d drops=%0d, required 4/1", count, drops);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_one(got, pc, inst);
      n_checks++;
      if (got !== 1'b1 || pc !== e || inst !== ~e) begin
        n_fails++;
        $display("FAIL stop_full_pop: valid=%b pc=%h inst=%h, required pc=%h inst=%h", got, pc, inst, e, ~e);
      end
    end
    n_checks++;
    if (bus.rd_valid !== 1'b0 || count !== '0) begin
      n_fails++;
      $display("FAIL stop_full_empty: rd_valid=%b count=%0d, required 0/0", bus.rd_valid, count);
    end
  endtask

  task automatic test_circular();
    logic got;
    logic [XLEN-1:0] pc, inst, e;
    do_clear();
    mode = 1'b1;
    en   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cap(XLEN'(32'h10 + 4 * i));
      exp_q.push_back(XLEN'(32'h10 + 4 * i));
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    end
    n_checks++;
    if (count !== CW'(4) || drops !== 16'd1) begin
      n_fails++;
      $display("FAIL circular_occupancy: count=%0d drops=%0d, required 4/1", count, drops);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_one(got, pc, inst);
      n_checks++;
      if (got !== 1'b1 || pc !== e || inst !== ~e) begin
        n_fails++;
        $display("FAIL circular_pop: valid=%b pc=%h inst=%h, required pc=%h inst=%h", got, pc, inst, e, ~e);
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_trigger();
    logic got;
    logic [XLEN-1:0] pc, inst, e;
    do_clear();
    mode = 1'b0;
    en   = 1'b1;
    trig = 1'b1;
    cap(32'h40);
    trig = 1'b0;
    cap(32'h44);
    n_checks++;
    if (frozen !== 1'b0) begin
      n_fails++;
      $display("FAIL trigger_early_freeze: frozen=%b after 0x44, required 0", frozen);
    end
    cap(32'h48);
    n_checks++;
    if (frozen !== 1'b1) begin
      n_fails++;
      $display("FAIL trigger_freeze: frozen=%b after 0x48, required 1", frozen);
    end
    cap(32'h4C);
    n_checks++;
    if (count !== CW'(3) || drops !== 16'd0) begin
      n_fails++;
      $display("FAIL trigger_frozen_capture: count=%0d drops=%0d, required 3/0", count, drops);
    end
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    exp_q.push_back(32'h48);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_one(got, pc, inst);
      n_checks++;
      if (got !== 1'b1 || pc !== e || inst !== ~e) begin
        n_fails++;
        $display("FAIL trigger_pop: valid=%b pc=%h inst=%h, required pc=%h inst=%h", got, pc, inst, e, ~e);
      end
    end
    n_checks++;
    if (frozen !== 1'b1 || count !== '0) begin
      n_fails++;
      $display("FAIL trigger_drained: frozen=%b count=%0d, required 1/0", frozen, count);
    end
  endtask

  task automatic test_full_concurrency();
    logic got;
    logic [XLEN-1:0] pc, inst, e;
    for (int m = 0; m < 2; m++) begin
      do_clear();
      mode = 1'(m);
      en   = 1'b1;
      for (int i = 0; i < 4; i++) begin
        cap(XLEN'(32'h60 + 4 * i));
        if (i > 0) exp_q.push_back(XLEN'(32'h60 + 4 * i));
      end
      exp_q.push_back(32'h70);
      n_checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_pc !== 32'h60) begin
        n_fails++;
        $display("FAIL concurrency_oldest mode=%0d: rd_valid=%b rd_pc=%h, required 1/00000060", m, bus.rd_valid, bus.rd_pc);
      end
      bus.rd_ready = 1'b1;
      cap(32'h70);
      bus.rd_ready = 1'b0;
      n_checks++;
      if (count !== CW'(4) || drops !== 16'd0) begin
        n_fails++;
        $display("FAIL concurrency_count mode=%0d: count=%0d drops=%0d, required 4/0", m, count, drops);
      end
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        pop_one(got, pc, inst);
        n_checks++;
        if (got !== 1'b1 || pc !== e || inst !== ~e) begin
          n_fails++;
          $display("FAIL concurrency_pop mode=%0d: valid=%b pc=%h, required pc=%h", m, got, pc, e);
        end
      end
    end
    mode = 1'b0;
  endtask

  task automatic test_clear();
    logic got;
    logic [XLEN-1:0] pc, inst, e;
    do_clear();
    mode = 1'b0;
    en   = 1'b1;
    for (int i = 0; i < 5; i++) cap(XLEN'(32'hA0 + 4 * i));
    // Trigger with capture disabled: arms POST, the request is ignored.
    en   = 1'b0;
    trig = 1'b1;
    cap(32'hBC);
    trig = 1'b0;
    n_checks++;
    if (count !== CW'(4) || drops !== 16'd1 || frozen !== 1'b0) begin
      n_fails++;
      $display("FAIL clear_en_low: count=%0d drops=%0d frozen=%b, required 4/1/0", count, drops, frozen);
    end
    en = 1'b1;
    cap(32'hC0);
    cap(32'hC4);
    cap(32'hC8);
    n_checks++;
    if (frozen !== 1'b1 || drops !== 16'd3) begin
      n_fails++;
      $display("FAIL clear_prefreeze: frozen=%b drops=%0d, required 1/3", frozen, drops);
    end
    clear = 1'b1;
    trig  = 1'b1;
    cap(32'hCC);
    clear = 1'b0;
    trig  = 1'b0;
    n_checks++;
    if (count !== '0 || drops !== 16'd0 || frozen !== 1'b0 || bus.rd_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL clear_override: count=%0d drops=%0d frozen=%b rd_valid=%b, required 0/0/0/0",
               count, drops, frozen, bus.rd_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cap(XLEN'(32'hD0 + 4 * i));
      exp_q.push_back(XLEN'(32'hD0 + 4 * i));
    end
    n_checks++;
    if (frozen !== 1'b0 || count !== CW'(3)) begin
      n_fails++;
      $display("FAIL clear_armed: frozen=%b count=%0d, required 0/3", frozen, count);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_one(got, pc, inst);
      n_checks++;
      if (got !== 1'b1 || pc !== e || inst !== ~e) begin
        n_fails++;
        $display("FAIL clear_pop: valid=%b pc=%h, required pc=%h", got, pc, e);
      end
    end
  endtask

  task automatic test_reset_mid_post();
    logic got;
    logic [XLEN-1:0] pc, inst, e;
    do_clear();
    en   = 1'b1;
    trig = 1'b1;
    cap(32'h80);
    trig = 1'b0;
    cap(32'h84);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.rd_valid !== 1'b0 || count !== '0 || frozen !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid_post: rd_valid=%b count=%0d frozen=%b, required 0/0/0", bus.rd_valid, count, frozen);
    end
    cycle();
    reset = 1'b1;
    cycle();
    trig = 1'b1;
    cycle();
    trig = 1'b0;
    cap(32'h90);
    n_checks++;
    if (frozen !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_restart_early: frozen=%b, required 0", frozen);
    end
    cap(32'h94);
    cap(32'h98);
    n_checks++;
    if (frozen !== 1'b1 || count !== CW'(2) || drops !== 16'd0) begin
      n_fails++;
      $display("FAIL reset_restart: frozen=%b count=%0d drops=%0d, required 1/2/0", frozen, count, drops);
    end
    exp_q.push_back(32'h90);
    exp_q.push_back(32'h94);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_one(got, pc, inst);
      n_checks++;
      if (got !== 1'b1 || pc !== e || inst !== ~e) begin
        n_fails++;
        $display("FAIL reset_restart_pop: valid=%b pc=%h, required pc=%h", got, pc, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic got;
    logic [XLEN-1:0] pc, inst, e;
    logic cv, rr;
    int exp_drops;
    exp_drops = 0;
    do_clear();
    mode = 1'b0;
    en   = 1'b1;
    for (int i = 0; i < 48; i++) begin
      cv = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      pc = $urandom;
      bus.cap_valid = cv;
      bus.cap_pc    = pc;
      bus.cap_inst  = ~pc;
      bus.rd_ready  = rr;
      #1;
      if (rr && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_pc !== e || bus.rd_inst !== ~e) begin
          n_fails++;
          $display("FAIL b2b_pop cycle %0d: valid=%b pc=%h, required pc=%h", i, bus.rd_valid, bus.rd_pc, e);
        end
      end
      if (cv) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pc);
        else exp_drops++;
      end
      cycle();
    end
    bus.cap_valid = 1'b0;
    bus.rd_ready  = 1'b0;
    n_checks++;
    if (count !== CW'(exp_q.size()) || drops !== 16'(exp_drops)) begin
      n_fails++;
      $display("FAIL b2b_totals: count=%0d drops=%0d, required %0d/%0d", count, drops, exp_q.size(), exp_drops);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      pop_one(got, pc, inst);
      n_checks++;
      if (got !== 1'b1 || pc !== e || inst !== ~e) begin
        n_fails++;
        $display("FAIL b2b_drain: valid=%b pc=%h, required pc=%h", got, pc, e);
      end
    end
  endtask

  initial begin
    reset         = 1'b0;
    en            = 1'b0;
    mode          = 1'b0;
    clear         = 1'b0;
    trig          = 1'b0;
    bus.cap_valid = 1'b0;
    bus.cap_pc    = '0;
    bus.cap_inst  = '0;
    bus.rd_ready  = 1'b0;

    test_reset();
    test_stop_when_full();
    test_circular();
    test_trigger();
    test_full_concurrency();
    test_clear();
    test_reset_mid_post();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
